alu_wb_stage: RTL

- Execute/write-back stage directly downstream of the 4-entry register group.
- Consumes the register group's read data (rd_q, rs_q) and its enable (en_out). Computes a 16-bit ALU result, including a multi-cycle shift-add multiply.
- Drives the register group's write port (d_in, reg_en) with a single-cycle one-hot write strobe, then signals completion.

---
 rtl/cpu_pkg.sv | 27 ++
 rtl/alu_wb_stage_mul_seq.sv | 52 +++++
 rtl/alu_wb_stage.sv | 113 +++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the execute/write-back stage: opcodes, FSM encoding,
// and the register-index one-hot decoder.
package cpu_pkg;

    localparam int WIDTH = 16;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_MUL = 3'b110;
    localparam logic [2:0] OP_MOV = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        MUL  = 2'd2,
        WB   = 2'd3
    } state_e;

    function automatic logic [3:0] idx2oh(input logic [1:0] idx);
        idx2oh = 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/alu_wb_stage_mul_seq.sv
// Iterative LSB-first shift-add multiplier; one multiplier bit per clock,
// done is asserted during the final iteration.
module mul_seq #(
    parameter int W   = 16,
    parameter int CYC = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           done,
    output logic [2*W-1:0] product
);

    localparam int CW = $clog2(CYC);

    logic           run_q;
    logic [CW-1:0]  cnt_q;
    logic [W-1:0]   mplier_q;
    logic [2*W-1:0] mcand_q;
    logic [2*W-1:0] acc_q;

    assign done    = run_q && (cnt_q == CW'(CYC - 1));
    assign product = acc_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_q    <= 1'b0;
            cnt_q    <= '0;
            mplier_q <= '0;
            mcand_q  <= '0;
            acc_q    <= '0;
        end else if (start) begin
            run_q    <= 1'b1;
            cnt_q    <= '0;
            mplier_q <= a;
            mcand_q  <= {{W{1'b0}}, b};
            acc_q    <= '0;
        end else if (run_q) begin
            // acc_q is final on the edge where done is high
            if (mplier_q[0])
                acc_q <= acc_q + mcand_q;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + 1'b1;
            if (done)
                run_q <= 1'b0;
        end
    end

endmodule

// File: rtl/alu_wb_stage.sv
// Execute/write-back stage: latches one request, computes the ALU result
// (multiply is iterative), then issues a single one-hot register write strobe.
module alu_wb_stage #(
    parameter int WIDTH   = 16,
    parameter int MUL_CYC = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_in,
    input  logic [2:0]       op,
    input  logic [1:0]       rd,
    input  logic [WIDTH-1:0] rd_q,
    input  logic [WIDTH-1:0] rs_q,
    output logic [WIDTH-1:0] d_out,
    output logic [3:0]       reg_en,
    output logic             zf,
    output logic             cf,
    output logic             busy,
    output logic             en_out
);

    import cpu_pkg::*;

    state_e               state_q;
    logic [2:0]           op_q;
    logic [1:0]           rd_idx_q;
    logic [WIDTH-1:0]     a_q;
    logic [WIDTH-1:0]     b_q;
    logic                 mul_start;
    logic                 mul_done;
    logic [2*WIDTH-1:0]   product;
    logic [WIDTH:0]       sum;
    logic [WIDTH:0]       diff;
    logic [WIDTH-1:0]     res_d;
    logic                 cf_d;

    assign mul_start = (state_q == IDLE) && en_in && (op == OP_MUL);

    mul_seq #(.W(WIDTH), .CYC(MUL_CYC)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .a       (rd_q),
        .b       (rs_q),
        .done    (mul_done),
        .product (product)
    );

    assign sum  = {1'b0, a_q} + {1'b0, b_q};
    assign diff = {1'b0, a_q} - {1'b0, b_q};

    always_comb begin
        res_d = '0;
        cf_d  = 1'b0;
        case (op_q)
            OP_ADD: begin res_d = sum[WIDTH-1:0];  cf_d = sum[WIDTH];  end
            OP_SUB: begin res_d = diff[WIDTH-1:0]; cf_d = diff[WIDTH]; end
            OP_AND: res_d = a_q & b_q;
            OP_OR:  res_d = a_q | b_q;
            OP_XOR: res_d = a_q ^ b_q;
            OP_SHL: begin res_d = {a_q[WIDTH-2:0], 1'b0}; cf_d = a_q[WIDTH-1]; end
            OP_MUL: begin
                res_d = product[WIDTH-1:0];
                cf_d  = |product[2*WIDTH-1:WIDTH];
            end
            OP_MOV: res_d = b_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            op_q     <= '0;
            rd_idx_q <= '0;
            a_q      <= '0;
            b_q      <= '0;
            d_out    <= '0;
            reg_en   <= '0;
            zf       <= 1'b0;
            cf       <= 1'b0;
            busy     <= 1'b0;
            en_out   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (en_in) begin
                    op_q     <= op;
                    rd_idx_q <= rd;
                    a_q      <= rd_q;
                    b_q      <= rs_q;
                    busy     <= 1'b1;
                    state_q  <= (op == OP_MUL) ? MUL : EXEC;
                end
                MUL: if (mul_done)
                    state_q <= EXEC;
                EXEC: begin
                    d_out   <= res_d;
                    zf      <= (res_d == '0);
                    cf      <= cf_d;
                    reg_en  <= idx2oh(rd_idx_q);
                    en_out  <= 1'b1;
                    state_q <= WB;
                end
                WB: begin
                    reg_en  <= '0;
                    en_out  <= 1'b0;
                    busy    <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule
